seven_segment_display_reader: RTL and testbench
===============================================

SEVEN_SEGMENT_DISPLAY_READER -- requirements
Module: seven_segment_display_reader

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 16, meaning the number of consecutive identical synchronized samples required before acceptance; legal range 2..65535.
REQ-002 The port clock SHALL be an input, 1 bit wide, and SHALL be the single clock; all state changes on its rising edge.
REQ-003 The port reset_n SHALL be an input, 1 bit wide, and SHALL be the asynchronous, active-low reset.
REQ-004 The port segs SHALL be an input, 28 bits wide, carrying four asynchronous external 7-segment patterns: digit0 = [6:0], digit1 = [13:7], digit2 = [20:14], digit3 = [27:21]; within each digit bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g, and 1 = segment lit.
REQ-005 The port number SHALL be an output, 16 bits wide, carrying the decoded value; [3:0] comes from digit0 and [15:12] from digit3.
REQ-006 The port digit_ok SHALL be an output, 4 bits wide; bit i = 1 means digit i holds a recognized hex pattern.
REQ-007 The port changed SHALL be an output, 1 bit wide, and SHALL pulse high for one cycle when a new accepted value differs from the previously accepted one.

Function
REQ-008 The block SHALL pass segs through a 2-stage synchronizer (s1, s2), 28 bits wide.
REQ-009 The block SHALL hold a register prev, loaded with s2 every cycle.
REQ-010 The stability counter SHALL:
- load 0 on any edge where s2 != prev;
- otherwise increment;
- saturate at STABLE_CYCLES.
REQ-011 Acceptance SHALL occur on the edge where s2 == prev and the counter equals STABLE_CYCLES-1: the 28-bit register stable <= s2.
REQ-012 On the edge following acceptance, the block SHALL register number and digit_ok from stable.
- On that same edge, changed SHALL be 1 iff the newly accepted stable differs from its value before acceptance; otherwise changed = 0.
REQ-013 Latency: for an input change that is applied before edge 1 and then held, number, digit_ok and changed SHALL update on edge STABLE_CYCLES+4 (edge STABLE_CYCLES+3 loads stable), exactly.
REQ-014 Any change of s2 before acceptance SHALL restart the count; glitches shorter than STABLE_CYCLES samples SHALL never reach the outputs.
REQ-015 While the counter is saturated and the input is unchanged, no further acceptance SHALL occur and changed SHALL stay 0.
REQ-016 Per-digit decode SHALL be exact match against this table (pattern -> nibble):
- 1111110->0, 0110000->1, 1101101->2, 1111001->3;
- 0110011->4, 1011011->5, 1011111->6, 1110000->7;
- 1111111->8, 1111011->9, 1110111->A, 0011111->B;
- 1001110->C, 0111101->D, 1001111->E, 1000111->F.
REQ-017 Any other pattern, including blank 0000000, SHALL decode to nibble 0 with digit_ok bit 0; the other digits SHALL be unaffected.
REQ-018 The counter width SHALL be 16 bits; counter arithmetic SHALL never wrap.

Reset
REQ-019 While reset_n = 0, the block SHALL asynchronously clear s1, s2, prev, counter and stable to 0 and drive number = 16'h0000, digit_ok = 4'b0000, changed = 0.
REQ-020 After reset release with segs = 0, no acceptance SHALL produce changed = 1, because accepted stable equals the reset value.
REQ-021 Reset asserted mid-count or during a changed pulse SHALL abort it immediately; acceptance SHALL restart from count 0 after release.

Verification (STABLE_CYCLES = 4)
REQ-022 Reset then segs = 0 held 20 cycles -> number 0000, digit_ok 0000, changed never 1.
REQ-023 segs = patterns {3:1111001, 2:1101101, 1:0110000, 0:1111110} (value 3210) applied before edge 1 -> on edge 8: number 16'h3210, digit_ok 1111, changed = 1 for exactly that cycle, then 0.
REQ-024 From stable 3210, digit0 changed to 1111111 for 3 cycles, then back -> outputs remain 3210 and changed stays 0.
REQ-025 digit3 = 0000000, digit2 = 1010101, digits 1..0 = 1110111, 1000111 -> number 16'h00AF, digit_ok 0011, one changed pulse.
REQ-026 Reapply identical 3210 value, then reassert reset at edge 5 of count and release -> outputs 0 at once; value 3210 accepted STABLE_CYCLES+4 edges after release with changed = 1.
REQ-027 All 16 table entries on digit0 in sequence, each held 10 cycles -> number[3:0] 0..F, digit_ok[0] = 1, one changed pulse per entry.

Source files
------------

// File: rtl/seven_segment_display_reader.sv
// Reads four asynchronous 7-segment patterns, debounces the whole 28-bit word
// and presents the decoded hex value with per-digit validity and a change strobe.
module seven_segment_display_reader #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [27:0] segs,
  output logic [15:0] number,
  output logic [3:0]  digit_ok,
  output logic        changed
);

  localparam logic [15:0] COUNT_SAT  = 16'(STABLE_CYCLES);
  localparam logic [15:0] COUNT_LAST = 16'(STABLE_CYCLES - 1);

  logic [27:0] s1, s2, prev;
  logic [27:0] stable, stable_old;
  logic [15:0] count;
  logic        accept, accept_d;
  logic [15:0] dec_num;
  logic [3:0]  dec_ok;

  // Returns {ok, nibble}; unknown patterns (blank included) give {0, 0}.
  function automatic logic [4:0] decode_digit(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1111110: r = {1'b1, 4'h0};
      7'b0110000: r = {1'b1, 4'h1};
      7'b1101101: r = {1'b1, 4'h2};
      7'b1111001: r = {1'b1, 4'h3};
      7'b0110011: r = {1'b1, 4'h4};
      7'b1011011: r = {1'b1, 4'h5};
      7'b1011111: r = {1'b1, 4'h6};
      7'b1110000: r = {1'b1, 4'h7};
      7'b1111111: r = {1'b1, 4'h8};
      7'b1111011: r = {1'b1, 4'h9};
      7'b1110111: r = {1'b1, 4'hA};
      7'b0011111: r = {1'b1, 4'hB};
      7'b1001110: r = {1'b1, 4'hC};
      7'b0111101: r = {1'b1, 4'hD};
      7'b1001111: r = {1'b1, 4'hE};
      7'b1000111: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  assign accept = (s2 == prev) && (count == COUNT_LAST);

  always_comb begin
    logic [4:0] d;
    dec_num = '0;
    dec_ok  = '0;
    for (int i = 0; i < 4; i++) begin
      d = decode_digit(stable[7*i +: 7]);
      dec_num[4*i +: 4] = d[3:0];
      dec_ok[i]         = d[4];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= segs;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Saturating at STABLE_CYCLES means acceptance fires once per stable run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (s2 != prev) begin
      count <= '0;
    end else if (count != COUNT_SAT) begin
      count <= count + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable     <= '0;
      stable_old <= '0;
      accept_d   <= 1'b0;
    end else begin
      accept_d <= accept;
      if (accept) begin
        stable     <= s2;
        stable_old <= stable;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      number   <= '0;
      digit_ok <= '0;
      changed  <= 1'b0;
    end else begin
      number   <= dec_num;
      digit_ok <= dec_ok;
      changed  <= accept_d && (stable != stable_old);
    end
  end

endmodule

// File: tb/tb_seven_segment_display_reader.sv
// Directed plus randomized bench for seven_segment_display_reader; a window-based
// reference model predicts every output on every clock edge.
module tb_seven_segment_display_reader;

  localparam int S   = 4;
  localparam int OFF = 3;
  localparam int HN  = 4096;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [27:0] segs = '0;
  logic [15:0] number;
  logic [3:0]  digit_ok;
  logic        changed;

  always #5 clock = ~clock;

  seven_segment_display_reader #(.STABLE_CYCLES(S)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .segs     (segs),
    .number   (number),
    .digit_ok (digit_ok),
    .changed  (changed)
  );

  localparam logic [6:0] PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  localparam logic [27:0] V3210 = {7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110};
  localparam logic [27:0] V00AF = {7'b0000000, 7'b1010101, 7'b1110111, 7'b1000111};

  int checks = 0;
  int fails  = 0;

  // hist[k+OFF] = segs value present just before edge k since the last reset release
  logic [27:0] hist [HN];
  int          k;
  int          flr;
  logic [27:0] m_stable, m_old;
  logic        m_acc_last;
  int          pulses;

  function automatic logic [19:0] ref_decode(input logic [27:0] v);
    logic [19:0] r;
    logic [6:0]  p;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      p = v[7*i +: 7];
      for (int j = 0; j < 16; j++)
        if (p == PAT[j]) begin
          r[4*i +: 4] = 4'(j);
          r[16 + i]   = 1'b1;
        end
    end
    return r;
  endfunction

  // Accepted at edge kk iff the synchronized sample seen at kk was preceded by a
  // run of exactly S+1 identical samples (counting from the post-reset origin).
  function automatic bit accept_at(input int kk);
    int e;
    e = kk - 2;
    if (e - S < flr) return 0;
    for (int j = e - S; j <= e; j++)
      if (hist[j + OFF] != hist[e + OFF]) return 0;
    if ((e - S - 1 >= flr) && (hist[e - S - 1 + OFF] == hist[e + OFF])) return 0;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k   = 0;
    flr = -2;
    for (int i = 0; i <= OFF; i++) hist[i] = '0;
    m_stable   = '0;
    m_old      = '0;
    m_acc_last = 1'b0;
  endtask

  task automatic tick();
    logic [19:0] r;
    bit          acc;
    if (k + 1 + OFF >= HN) begin
      $display("FAIL history: bench history overflow at k=%0d", k);
      $fatal(1, "history overflow");
    end
    hist[k + 1 + OFF] = segs;
    @(posedge clock);
    #1;
    k++;
    r = ref_decode(m_stable);
    check("number",   32'(number),   32'(r[15:0]));
    check("digit_ok", 32'(digit_ok), 32'(r[19:16]));
    check("changed",  32'(changed),  32'(m_acc_last && (m_stable != m_old)));
    if (changed) pulses++;
    acc = accept_at(k);
    if (acc) begin
      m_old    = m_stable;
      m_stable = hist[k - 2 + OFF];
    end
    m_acc_last = acc;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_number",   32'(number),   32'h0);
    check("rst_digit_ok", 32'(digit_ok), 32'h0);
    check("rst_changed",  32'(changed),  32'h0);
    repeat (2) @(posedge clock);
    #4;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [27:0] v;
    int          n;

    model_reset();
    do_reset();

    // Held zero after reset: the accepted value equals the reset value.
    segs   = '0;
    pulses = 0;
    repeat (20) tick();
    check("zero_no_pulse", 32'(pulses), 32'h0);

    // 3210 appears on the 8th edge after it is applied, pulse lasts one cycle.
    segs = V3210;
    repeat (7) tick();
    check("3210_early", 32'(number), 32'h0);
    tick();
    check("3210_number", 32'(number),   32'h3210);
    check("3210_ok",     32'(digit_ok), 32'hF);
    check("3210_pulse",  32'(changed),  32'h1);
    tick();
    check("3210_pulse_end", 32'(changed), 32'h0);
    repeat (4) tick();

    // Three-sample glitch on digit0 must be filtered.
    pulses = 0;
    segs = {V3210[27:7], 7'b1111111};
    repeat (3) tick();
    segs = V3210;
    repeat (14) tick();
    check("glitch_number", 32'(number), 32'h3210);
    check("glitch_pulses", 32'(pulses), 32'h0);

    // Blank and unknown digits decode to 0 with ok cleared.
    pulses = 0;
    segs = V00AF;
    repeat (12) tick();
    check("00af_number", 32'(number),   32'h00AF);
    check("00af_ok",     32'(digit_ok), 32'h3);
    check("00af_pulses", 32'(pulses),   32'h1);

    // Reset mid-count aborts; acceptance restarts after release.
    segs = V3210;
    repeat (5) tick();
    do_reset();
    repeat (7) tick();
    check("rr_early", 32'(number), 32'h0);
    tick();
    check("rr_number", 32'(number),  32'h3210);
    check("rr_pulse",  32'(changed), 32'h1);
    repeat (4) tick();

    // Every table entry on digit0.
    for (int j = 0; j < 16; j++) begin
      pulses = 0;
      segs = {21'b0, PAT[j]};
      repeat (10) tick();
      check("tbl_nibble", 32'(number[3:0]), 32'(j));
      check("tbl_ok",     32'(digit_ok[0]), 32'h1);
      check("tbl_pulses", 32'(pulses),      32'h1);
    end

    // Randomized words with random hold times, including sub-threshold glitches.
    for (int t = 0; t < 160; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        v = 28'($urandom);
      end else begin
        for (int i = 0; i < 4; i++)
          v[7*i +: 7] = ($urandom_range(0, 5) == 0) ? 7'($urandom) : PAT[$urandom_range(0, 15)];
      end
      if ($urandom_range(0, 5) != 0) segs = v;
      n = $urandom_range(1, 9);
      repeat (n) tick();
      if (t == 80) begin
        do_reset();
        repeat (3) tick();
      end
    end
    repeat (12) tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
